// File: rtl/tate_result_reader_pkg.sv
// Shared constants, FSM state type and helpers for the Tate-pairing result reader.
package tate_result_reader_pkg;

    localparam int unsigned M_DEFAULT = 97;
    localparam int unsigned NCOEF     = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/f3m_trit_check.sv
// Flags a GF(3^m) element that contains any 2'b11 (invalid) trit.
module f3m_trit_check #(
    parameter int unsigned M = 97
) (
    input  logic [2*M-1:0] elem,
    output logic           bad
);

    always_comb begin
        bad = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            if (elem[2*i +: 2] == 2'b11) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tate_result_reader.sv
// Captures the F(3^6m) pairing result on a done rising edge and streams it as W-bit words.
module tate_result_reader
    import tate_result_reader_pkg::*;
#(
    parameter int unsigned M = M_DEFAULT,
    parameter int unsigned W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_done,
    input  logic [12*M-1:0] core_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic [2:0]    m_coef,
    output logic          m_last,
    output logic          busy,
    output logic          err,
    output logic          ovf
);

    localparam int unsigned WIDTH = 2*M - 1;
    localparam int unsigned W6    = 12*M - 1;
    localparam int unsigned E     = WIDTH + 1;
    localparam int unsigned NCH   = ceil_div(E, W);
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);

    state_t                 state;
    logic                   done_q;
    logic [NCOEF-1:0][WIDTH:0] shadow;
    logic [CW-1:0]          c;
    logic [2:0]             k;
    logic [CW-1:0]          nxt_c;
    logic [2:0]             nxt_k;
    logic [NCOEF-1:0]       bad;
    logic                   rise;
    logic                   hs;

    for (genvar i = 0; i < NCOEF; i++) begin : g_chk
        f3m_trit_check #(.M(M)) u_chk (
            .elem (core_out[E*i +: E]),
            .bad  (bad[i])
        );
    end

    // Zero-pads coefficient k up to NCH*W bits, then picks chunk c.
    function automatic logic [W-1:0] word_of(input logic [NCOEF-1:0][WIDTH:0] frame,
                                             input logic [2:0] kk,
                                             input logic [CW-1:0] cc);
        logic [NCH*W-1:0]        flat;
        logic [NCH-1:0][W-1:0]   chunks;
        flat         = '0;
        flat[WIDTH:0] = frame[kk];
        chunks       = flat;
        return chunks[cc];
    endfunction

    assign rise = core_done & ~done_q;
    assign hs   = m_valid & m_ready;

    always_comb begin
        nxt_c = c + CW'(1);
        nxt_k = k;
        if (c == C_LAST) begin
            nxt_c = '0;
            nxt_k = k + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            shadow  <= '0;
            c       <= '0;
            k       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_coef  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done_q <= core_done;
            case (state)
                IDLE: begin
                    if (rise) begin
                        shadow  <= core_out;
                        err     <= |bad;
                        c       <= '0;
                        k       <= '0;
                        // First word comes straight from core_out so it is valid one edge after capture.
                        m_data  <= word_of(core_out, 3'd0, '0);
                        m_coef  <= 3'd0;
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (rise) begin
                        ovf <= 1'b1;
                    end
                    if (hs) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_data  <= '0;
                            m_coef  <= '0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            c       <= '0;
                            k       <= '0;
                            state   <= IDLE;
                        end else begin
                            c       <= nxt_c;
                            k       <= nxt_k;
                            m_data  <= word_of(shadow, nxt_k, nxt_c);
                            m_coef  <= nxt_k;
                            m_last  <= (nxt_k == 3'd5) && (nxt_c == C_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tate_result_reader.sv
// Directed bench for tate_result_reader (M=97, W=32: 7 words per coefficient, 42 per frame).
module tb_tate_result_reader;

    localparam int unsigned M  = 97;
    localparam int unsigned W  = 32;
    localparam int unsigned FB = 12*M;
    localparam int unsigned EB = 2*M;
    localparam int          NBEAT = 42;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_done;
    logic [FB-1:0] core_out;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [2:0]    m_coef;
    logic          m_last;
    logic          busy;
    logic          err;
    logic          ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] words     [NBEAT];
    logic [31:0] ref_words [NBEAT];

    tate_result_reader #(.M(M), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .core_done (core_done),
        .core_out  (core_out),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_coef    (m_coef),
        .m_last    (m_last),
        .busy      (busy),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit-level reference: word for coefficient k, chunk c, with zero padding past bit 193.
    function automatic logic [31:0] exp_word(input logic [FB-1:0] f, input int k, input int c);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            if (c*32 + b < int'(EB)) w[b] = f[int'(EB)*k + c*32 + b];
        end
        return w;
    endfunction

    // Drives m_ready and checks every beat; optional done pulse (pulse_at) or reset abort (abort_at).
    task automatic run_frame(input logic [FB-1:0] frame, input logic exp_err, input int pct,
                             input int pulse_at, input logic [FB-1:0] alt, input int abort_at,
                             output int beats);
        int   cyc;
        bit   fin;
        bit   stalled;
        bit   rdy;
        logic [31:0] hd;
        logic [2:0]  hk;
        logic        hl;
        beats = 0; cyc = 0; fin = 0; stalled = 0;
        hd = '0; hk = '0; hl = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) check("latency_valid_busy", {62'd0, m_valid, busy}, 64'd3);
            if (pulse_at >= 0 && cyc == pulse_at) begin
                core_done = 1'b0;
                core_out  = alt;
            end
            if (pulse_at >= 0 && cyc == pulse_at + 1) core_done = 1'b1;
            if (abort_at >= 0 && beats == abort_at) begin
                #2 reset = 1'b1;
                #1 check("async_reset_outputs",
                         {22'd0, m_valid, m_data, m_coef, m_last, busy, err, ovf}, 64'd0);
                fin = 1;
            end else begin
                if (stalled)
                    check($sformatf("stall_hold_b%0d", beats), {27'd0, m_valid, m_coef, m_last, m_data},
                          {27'd0, 1'b1, hk, hl, hd});
                if (m_valid) begin
                    if (beats < NBEAT)
                        check($sformatf("beat_%0d", beats),
                              {26'd0, busy, err, m_coef, m_last, m_data},
                              {26'd0, 1'b1, exp_err, 3'(beats / 7), (beats == NBEAT-1),
                               exp_word(frame, beats / 7, beats % 7)});
                    else
                        check("extra_beat", 64'(beats), 64'(NBEAT - 1));
                end
                rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
                m_ready = rdy;
                if (m_valid && rdy) begin
                    if (beats < NBEAT) words[beats] = m_data;
                    beats++;
                    if (m_last) fin = 1;
                    stalled = 0;
                end else begin
                    stalled = m_valid;
                    hd = m_data; hk = m_coef; hl = m_last;
                end
            end
            cyc++;
        end
        if (!fin) check("frame_timeout", 64'(cyc), 64'd0);
    endtask

    task automatic start_frame(input logic [FB-1:0] frame);
        @(negedge clk);
        core_out  = frame;
        core_done = 1'b1;
    endtask

    task automatic idle_count(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
    endtask

    initial begin
        logic [FB-1:0] f_unity, f_pad, f_bad, f_rand, f_alt;
        int beats;
        int seen;

        f_unity = '0; f_unity[0] = 1'b1;
        f_pad   = {(FB/2){2'b10}};
        f_bad   = '0; f_bad[3*EB +: 2] = 2'b11;
        f_alt   = {(FB/2){2'b01}};
        f_rand  = '0;
        for (int i = 0; i < int'(FB/2); i++) f_rand[2*i +: 2] = 2'($urandom_range(2));

        reset = 1'b1; core_done = 1'b0; core_out = '0; m_ready = 1'b0;
        #12;
        check("reset_outputs", {22'd0, m_valid, m_data, m_coef, m_last, busy, err, ovf}, 64'd0);
        @(negedge clk) reset = 1'b0;

        // Unity result
        start_frame(f_unity);
        run_frame(f_unity, 1'b0, 100, -1, '0, -1, beats);
        check("unity_beats", 64'(beats), 64'(NBEAT));
        check("unity_word0", 64'(words[0]), 64'h1);
        check("unity_word1", 64'(words[1]), 64'h0);
        @(negedge clk);
        check("unity_after_idle", {61'd0, m_valid, busy, ovf}, 64'd0);
        core_done = 1'b0;

        // Padding / order
        start_frame(f_pad);
        run_frame(f_pad, 1'b0, 100, -1, '0, -1, beats);
        check("pad_beats", 64'(beats), 64'(NBEAT));
        check("pad_chunk0", 64'(words[0]), 64'hAAAAAAAA);
        check("pad_chunk6", 64'(words[6]), 64'h00000002);
        check("pad_chunk41", 64'(words[41]), 64'h00000002);
        @(negedge clk) core_done = 1'b0;

        // Backpressure: reference run unstalled, then at 30% ready
        start_frame(f_rand);
        run_frame(f_rand, 1'b0, 100, -1, '0, -1, beats);
        for (int i = 0; i < NBEAT; i++) ref_words[i] = words[i];
        @(negedge clk) core_done = 1'b0;
        start_frame(f_rand);
        run_frame(f_rand, 1'b0, 30, -1, '0, -1, beats);
        check("bp_beats", 64'(beats), 64'(NBEAT));
        for (int i = 0; i < NBEAT; i++)
            check($sformatf("bp_payload_%0d", i), 64'(words[i]), 64'(ref_words[i]));
        @(negedge clk) core_done = 1'b0;

        // Invalid trit
        start_frame(f_bad);
        run_frame(f_bad, 1'b1, 100, -1, '0, -1, beats);
        check("bad_beats", 64'(beats), 64'(NBEAT));
        check("bad_word21", 64'(words[21]), 64'h3);
        @(negedge clk);
        check("bad_err_held", {63'd0, err}, 64'd1);
        core_done = 1'b0;

        // Level held 200 cycles: exactly one frame
        start_frame(f_unity);
        run_frame(f_unity, 1'b0, 100, -1, '0, -1, beats);
        check("level_beats", 64'(beats), 64'(NBEAT));
        idle_count(200 - NBEAT - 1, seen);
        check("level_no_retrigger", 64'(seen), 64'd0);
        check("level_ovf_clear", {63'd0, ovf}, 64'd0);

        // Mid-frame re-trigger: ovf set, shadow untouched, no replay
        core_done = 1'b0;
        start_frame(f_pad);
        run_frame(f_pad, 1'b0, 100, 5, f_alt, -1, beats);
        check("retrig_beats", 64'(beats), 64'(NBEAT));
        idle_count(60, seen);
        check("retrig_no_replay", 64'(seen), 64'd0);
        check("retrig_ovf", {63'd0, ovf}, 64'd1);

        // Reset mid-frame, then done held high across release restarts a full frame
        core_done = 1'b0;
        start_frame(f_rand);
        run_frame(f_rand, 1'b0, 100, -1, '0, 10, beats);
        core_out = f_pad;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame(f_pad, 1'b0, 100, -1, '0, -1, beats);
        check("post_reset_beats", 64'(beats), 64'(NBEAT));
        check("post_reset_word0", 64'(words[0]), 64'hAAAAAAAA);
        check("post_reset_ovf", {63'd0, ovf}, 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
